// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} one quotient bit per clock after accept.
module div_unit #(
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o
);

   localparam int unsigned CNT_W = $clog2(DATA_W);
   localparam int unsigned RES_W = 2 * DATA_W;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_BYZERO = 2'd1,
      ST_ON     = 2'd2,
      ST_END    = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   dvd_q, dvd_d;
   logic [DATA_W-1:0]   dvs_q, dvs_d;
   logic [DATA_W-1:0]   rem_q, rem_d;
   logic                neg_quo_q, neg_quo_d;
   logic                neg_rem_q, neg_rem_d;
   logic [RES_W-1:0]    result_q, result_d;
   logic                ready_q, ready_d;

   logic                op1_neg_c, op2_neg_c;
   logic [DATA_W-1:0]   abs1_c, abs2_c;
   logic [DATA_W:0]     partial_c;
   logic [DATA_W+1:0]   trial_c;
   logic                qbit_c;
   logic [DATA_W-1:0]   rem_nxt_c, quo_nxt_c, rem_fix_c, quo_fix_c;

   // Operand magnitudes; negation wraps, so the most negative value maps to itself
   always_comb begin
      op1_neg_c = signed_div_i & opdata1_i[DATA_W-1];
      op2_neg_c = signed_div_i & opdata2_i[DATA_W-1];
      abs1_c    = op1_neg_c ? (~opdata1_i + ONE) : opdata1_i;
      abs2_c    = op2_neg_c ? (~opdata2_i + ONE) : opdata2_i;
   end

   // One restoring step: the dividend register shifts out its MSB and takes in the quotient bit
   always_comb begin
      partial_c = {rem_q, dvd_q[DATA_W-1]};
      trial_c   = {1'b0, partial_c} - {2'b00, dvs_q};
      qbit_c    = ~trial_c[DATA_W+1];
      rem_nxt_c = qbit_c ? trial_c[DATA_W-1:0] : partial_c[DATA_W-1:0];
      quo_nxt_c = {dvd_q[DATA_W-2:0], qbit_c};
      quo_fix_c = neg_quo_q ? (~quo_nxt_c + ONE) : quo_nxt_c;
      rem_fix_c = neg_rem_q ? (~rem_nxt_c + ONE) : rem_nxt_c;
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      ready_d   = ready_q;

      unique case (state_q)
         ST_FREE: begin
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_d = ST_BYZERO;
               end else begin
                  state_d   = ST_ON;
                  cnt_d     = '0;
                  dvd_d     = abs1_c;
                  dvs_d     = abs2_c;
                  rem_d     = '0;
                  neg_quo_d = op1_neg_c ^ op2_neg_c;
                  neg_rem_d = op1_neg_c;
               end
            end
         end
         ST_BYZERO: begin
            state_d  = ST_END;
            result_d = '0;
            ready_d  = 1'b1;
         end
         ST_ON: begin
            if (annul_i) begin
               state_d  = ST_FREE;
               result_d = '0;
               ready_d  = 1'b0;
            end else begin
               dvd_d = quo_nxt_c;
               rem_d = rem_nxt_c;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d  = ST_END;
                  result_d = {rem_fix_c, quo_fix_c};
                  ready_d  = 1'b1;
               end
            end
         end
         ST_END: begin
            if (!start_i) begin
               state_d  = ST_FREE;
               result_d = '0;
               ready_d  = 1'b0;
            end
         end
         default: begin
            state_d  = ST_FREE;
            result_d = '0;
            ready_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_FREE;
         cnt_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule
